// File: rtl/dmem_bridge.sv
// Purpose: CPU data-memory port to wait-stated bus bridge with a posted write buffer and sticky timeout error.
// Latency: stores post in 0 cycles (bus write starts 2 cycles later); loads on an empty buffer return in 3 cycles.
// Backpressure: cpu_stall while the write buffer is full on a store, and for every load until its data returns.
//
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   cpu_addr/byte_slct/wdata     CPU MEM-stage request fields
//   cpu_we, cpu_re               CPU store / load request levels (store wins if both high)
//   cpu_rdata, cpu_stall         load data (valid when stall falls on a load), pipeline hold
//   mem_req/we/addr/be/wdata     bus request, held stable until mem_ack
//   mem_ack, mem_rdata           bus completion and read data
//   bus_err                      sticky timeout flag
module dmem_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WBUF_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [3:0]        cpu_byte_slct,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bus_err
);

   localparam int PTR_W = $clog2(WBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WBUF_DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [3:0]        be;
      logic [DATA_W-1:0] data;
   } wbuf_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_RESP,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   wbuf_t              wbuf_q [WBUF_DEPTH];
   wbuf_t              head;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [7:0]         tmo_q, tmo_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               bus_err_q, bus_err_d;
   logic               resp_prev_q;

   logic               full, empty, ld_req, push, pop;
   logic               in_bus, acked, timed_out, done;

   // A simultaneous load+store is a store; the load side only sees pure loads.
   assign ld_req    = cpu_re & ~cpu_we;
   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == '0);
   // Fullness is judged before this edge's pop, so a full buffer never accepts
   // a push even in the cycle its head is retired.
   assign push      = cpu_we & ~full;

   assign in_bus    = (state_q == S_WR) || (state_q == S_RD);
   assign acked     = in_bus & mem_ack;
   // Fires in the TIMEOUT-th unacknowledged bus cycle; the access then finishes as if acked.
   assign timed_out = in_bus & ~mem_ack & (tmo_q == TMO_LAST);
   assign done      = acked | timed_out;
   assign pop       = (state_q == S_WR) & done;

   assign head      = wbuf_q[rd_ptr_q];

   assign cpu_stall = (cpu_we & full) | (ld_req & (state_q != S_RESP));
   assign cpu_rdata = rdata_q;
   assign bus_err   = bus_err_q;

   always_comb begin
      state_d   = state_q;
      tmo_d     = '0;
      rdata_d   = rdata_q;
      bus_err_d = bus_err_q | timed_out;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      unique case (state_q)
         S_IDLE: begin
            // Older stores always go first, which keeps store-to-load ordering.
            // The RESP check stops a still-asserted load from being reissued.
            if (!empty) begin
               state_d = S_WR;
            end else if (ld_req && !resp_prev_q) begin
               state_d = S_RD;
            end
         end
         S_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_be    = head.be;
            mem_wdata = head.data;
            if (done) begin
               state_d = S_GAP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_RD: begin
            mem_req  = 1'b1;
            mem_addr = cpu_addr;
            mem_be   = cpu_byte_slct;
            if (acked) begin
               rdata_d = mem_rdata;
               state_d = S_RESP;
            end else if (timed_out) begin
               rdata_d = '0;
               state_d = S_RESP;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tmo_q       <= '0;
         rdata_q     <= '0;
         bus_err_q   <= 1'b0;
         resp_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         rdata_q     <= rdata_d;
         bus_err_q   <= bus_err_d;
         resp_prev_q <= (state_q == S_RESP);
         count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Buffer storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         wbuf_q[wr_ptr_q] <= '{addr: cpu_addr, be: cpu_byte_slct, data: cpu_wdata};
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [3:0]  cpu_byte_slct;
   logic [31:0] cpu_wdata;
   logic        cpu_we;
   logic        cpu_re;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        bus_err;

   dmem_bridge #(.ADDR_W(32), .DATA_W(32), .WBUF_DEPTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_byte_slct(cpu_byte_slct), .cpu_wdata(cpu_wdata),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_t;

   int          n_checks = 0;
   int          n_errors = 0;
   wr_t         wr_q [$];
   logic [31:0] rd_q [$];
   logic [31:0] mem_model [logic [31:0]];
   bit          ack_en = 1'b1;
   int          ack_delay = 0;

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem_model.exists(a >> 2)) return mem_model[a >> 2];
      return 32'h0;
   endfunction

   // Bus memory model: acks after ack_delay unacknowledged request cycles.
   initial begin
      int req_cnt;
      req_cnt   = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_req && rst) begin
            req_cnt++;
            if (ack_en && req_cnt > ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_we ? 32'h0 : rd_word(mem_addr);
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = '0;
            end
         end else begin
            req_cnt   = 0;
            mem_ack   = 1'b0;
            mem_rdata = '0;
         end
      end
   end

   // Bus monitor: write scoreboard, field stability, gap and ordering.
   initial begin
      logic        p_req, p_ack, p_we;
      logic [31:0] p_addr, p_data;
      logic [3:0]  p_be;
      wr_t         exp;
      logic [31:0] w;
      p_req = 1'b0; p_ack = 1'b0; p_we = 1'b0; p_addr = '0; p_data = '0; p_be = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            p_req = 1'b0;
            p_ack = 1'b0;
         end else begin
            if (p_req && p_ack) begin
               n_checks++;
               if (mem_req !== 1'b0) begin
                  n_errors++;
                  $display("FAIL bus_gap: mem_req=%b after ack, expected 0", mem_req);
               end
            end
            if (mem_req && p_req && !p_ack) begin
               n_checks++;
               if ({mem_we, mem_addr, mem_be, mem_wdata} !== {p_we, p_addr, p_be, p_data}) begin
                  n_errors++;
                  $display("FAIL bus_stable: we=%b addr=%h be=%h data=%h, held were we=%b addr=%h be=%h data=%h",
                           mem_we, mem_addr, mem_be, mem_wdata, p_we, p_addr, p_be, p_data);
               end
            end
            if (mem_req && mem_ack) begin
               n_checks++;
               if (mem_we) begin
                  if (wr_q.size() == 0) begin
                     n_errors++;
                     $display("FAIL bus_write: unexpected write addr=%h, expected none", mem_addr);
                  end else begin
                     exp = wr_q.pop_front();
                     if ({mem_addr, mem_be, mem_wdata} !== {exp.addr, exp.be, exp.data}) begin
                        n_errors++;
                        $display("FAIL bus_write: addr=%h be=%h data=%h, expected addr=%h be=%h data=%h",
                                 mem_addr, mem_be, mem_wdata, exp.addr, exp.be, exp.data);
                     end
                     w = rd_word(mem_addr);
                     for (int i = 0; i < 4; i++)
                        if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                     mem_model[mem_addr >> 2] = w;
                  end
               end else if (wr_q.size() != 0) begin
                  n_errors++;
                  $display("FAIL load_order: read acked with %0d stores pending, expected 0", wr_q.size());
               end
            end
            p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
            p_addr = mem_addr; p_be = mem_be; p_data = mem_wdata;
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b0;
      cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_byte_slct = '0; cpu_wdata = '0;
      ack_en = 1'b1; ack_delay = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      wr_q.delete();
      rd_q.delete();
   endtask

   task automatic cpu_idle();
      @(posedge clk);
      #1;
      cpu_we = 1'b0;
      cpu_re = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                           output int stalls);
      stalls = 0;
      @(posedge clk);
      #1;
      cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = a; cpu_byte_slct = be; cpu_wdata = d;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            wr_q.push_back('{addr: a, be: be, data: d});
            return;
         end
         stalls++;
         @(posedge clk);
         #1;
      end
      n_checks++; n_errors++;
      $display("FAIL store_accept: still stalled after 200 cycles, expected release");
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] exp,
                          output int stalls, output int rd_reqs);
      logic [31:0] e;
      stalls = 0; rd_reqs = 0;
      @(posedge clk);
      #1;
      cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_byte_slct = 4'hF;
      rd_q.push_back(exp);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            e = rd_q.pop_front();
            n_checks++;
            if (cpu_rdata !== e) begin
               n_errors++;
               $display("FAIL load_data: addr=%h rdata=%h, expected %h", a, cpu_rdata, e);
            end
            return;
         end
         stalls++;
         if (mem_req && !mem_we) rd_reqs++;
         @(posedge clk);
         #1;
      end
      rd_q.delete();
      n_checks++; n_errors++;
      $display("FAIL load_release: stall never fell after 300 cycles, expected release");
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (wr_q.size() == 0 && !mem_req) break;
      end
      n_checks++;
      if (wr_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d stores never written, expected 0", wr_q.size());
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      check_val("reset_mem_req", 32'(mem_req), 32'd0);
      check_val("reset_cpu_stall", 32'(cpu_stall), 32'd0);
      check_val("reset_bus_err", 32'(bus_err), 32'd0);
      check_val("reset_cpu_rdata", cpu_rdata, 32'd0);
   endtask

   task automatic test_reset_mid_wr();
      int s;
      apply_reset();
      ack_en = 1'b0;
      for (int i = 0; i < 3; i++) do_store(32'h100 + 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i), s);
      cpu_idle();
      @(negedge clk);
      check_val("t1_wr_in_flight", {30'd0, mem_req, mem_we}, 32'd3);
      check_val("t1_wr_addr", mem_addr, 32'h100);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      wr_q.delete();
      ack_en = 1'b1;
      @(negedge clk);
      check_val("t1_req_dropped", 32'(mem_req), 32'd0);
      check_val("t1_bus_err", 32'(bus_err), 32'd0);
      check_val("t1_cpu_stall", 32'(cpu_stall), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("t1_fifo_empty_no_req", 32'(mem_req), 32'd0);
      end
   endtask

   task automatic test_posted_stores();
      int s;
      apply_reset();
      ack_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_store(32'h10 + 32'(4 * i), 4'hF, 32'h1111_0000 + 32'(i), s);
         check_val("t2_posted_no_stall", 32'(s), 32'd0);
      end
      // Fifth store meets a full buffer; a slot only frees one cycle after the first ack.
      @(posedge clk);
      #1;
      cpu_addr = 32'h24; cpu_wdata = 32'h5555_AAAA; cpu_byte_slct = 4'hF; cpu_we = 1'b1;
      @(negedge clk);
      check_val("t2_fifth_stalls", 32'(cpu_stall), 32'd1);
      ack_en = 1'b1;
      s = 1;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (!cpu_stall) break;
         s++;
      end
      wr_q.push_back('{addr: 32'h24, be: 4'hF, data: 32'h5555_AAAA});
      check_val("t2_fifth_stall_cycles", 32'(s), 32'd2);
      cpu_idle();
      drain();
   endtask

   task automatic test_load_after_store();
      int s, r, st;
      apply_reset();
      ack_delay = 1;
      do_store(32'h20, 4'hF, 32'hCAFE_BABE, st);
      do_load(32'h20, 32'hCAFE_BABE, s, r);
      cpu_idle();
      check_val("t3_load_stall_cycles", 32'(s), 32'd7);
      check_val("t3_rd_req_cycles", 32'(r), 32'd2);
   endtask

   task automatic test_byte_lanes();
      int s, r, n;
      apply_reset();
      ack_delay = 3;
      do_store(32'h30, 4'b0010, 32'hA5A5_5A5A, s);
      cpu_idle();
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mem_req) begin
            n++;
            check_val("t4_mem_be", 32'(mem_be), 32'h2);
            check_val("t4_mem_wdata", mem_wdata, 32'hA5A5_5A5A);
         end else if (n != 0) begin
            break;
         end
      end
      check_val("t4_req_cycles", 32'(n), 32'd4);
      drain();
      ack_delay = 0;
      do_load(32'h30, 32'h0000_5A00, s, r);
      cpu_idle();
   endtask

   task automatic test_wait_states();
      int s, r;
      apply_reset();
      mem_model[32'h40 >> 2] = 32'h1234_5678;
      ack_delay = 5;
      do_load(32'h40, 32'h1234_5678, s, r);
      check_val("t5_req_cycles", 32'(r), 32'd6);
      check_val("t5_stall_cycles", 32'(s), 32'd7);
      cpu_idle();
      @(negedge clk);
      check_val("t5_after_resp_req", {30'd0, mem_req, cpu_stall}, 32'd0);
   endtask

   task automatic test_back_to_back();
      int s, r;
      apply_reset();
      mem_model[32'h44 >> 2] = 32'h0BAD_F00D;
      do_load(32'h40, 32'h1234_5678, s, r);
      check_val("b2b_first_latency", 32'(s), 32'd2);
      check_val("b2b_first_req", 32'(r), 32'd1);
      do_load(32'h44, 32'h0BAD_F00D, s, r);
      check_val("b2b_second_latency", 32'(s), 32'd3);
      check_val("b2b_second_req", 32'(r), 32'd1);
      cpu_idle();
   endtask

   task automatic test_timeout();
      int s, r;
      apply_reset();
      mem_model[32'h50 >> 2] = 32'hFFFF_FFFF;
      ack_en = 1'b0;
      @(negedge clk);
      check_val("t6_err_before", 32'(bus_err), 32'd0);
      do_load(32'h50, 32'h0, s, r);
      check_val("t6_err_set", 32'(bus_err), 32'd1);
      check_val("t6_rd_req_cycles", 32'(r), 32'd8);
      check_val("t6_stall_cycles", 32'(s), 32'd9);
      cpu_idle();
      ack_en = 1'b1;
      do_store(32'h60, 4'hF, 32'h6060_6060, s);
      cpu_idle();
      drain();
      check_val("t6_err_sticky", 32'(bus_err), 32'd1);
      apply_reset();
      @(negedge clk);
      check_val("t6_err_cleared", 32'(bus_err), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_mid_wr();
      test_posted_stores();
      test_load_after_store();
      test_byte_lanes();
      test_wait_states();
      test_back_to_back();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
